// File: rtl/m_axi_lite_dma_v2.sv
// m_axi_lite_dma_v2: AXI4-Lite master DMA, pattern write/readback-compare (MODE 0) or word copy (MODE 1).
// One transaction outstanding at a time; errors are counted per beat and latched into a sticky flag.
module m_axi_lite_dma_v2 #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_SRC_BASE = 32'h4000_0000,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_DST_BASE = 32'h4000_1000,
  parameter int C_MAX_WORDS = 1024,
  localparam int LW = $clog2(C_MAX_WORDS) + 1
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic                              INIT_AXI_TXN,
  input  logic                              MODE,
  input  logic [LW-1:0]                     XFER_LEN,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     SEED,
  output logic                              TXN_DONE,
  output logic                              ERROR,
  output logic                              BUSY,
  output logic [15:0]                       ERR_COUNT,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SH = $clog2(DW / 8);
  localparam logic [LW-1:0] MAXW = LW'(C_MAX_WORDS);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

  state_t state_q, state_d;
  logic init_q, init_prev_q, start;
  logic mode_q, mode_d;
  logic [LW-1:0] len_q, len_d, idx_q, idx_d, nxt, len_in;
  logic [DW-1:0] seed_q, seed_d, wdata_q, wdata_d;
  logic [AW-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] sum;
  logic [1:0] inc;
  logic last, miss;

  function automatic logic [AW-1:0] off(input logic [LW-1:0] n);
    return AW'(n) << SH;
  endfunction

  assign start = init_q & ~init_prev_q;

  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    len_d = len_q;
    seed_d = seed_q;
    idx_d = idx_q;
    wdata_d = wdata_q;
    awaddr_d = awaddr_q;
    araddr_d = araddr_q;
    awvalid_d = awvalid_q;
    wvalid_d = wvalid_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d = err_q;
    cnt_d = cnt_q;
    inc = 2'd0;
    nxt = idx_q + 1'b1;
    last = nxt == len_q;
    len_in = XFER_LEN > MAXW ? MAXW : XFER_LEN;
    miss = M_AXI_RDATA != seed_q + DW'(idx_q);
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
        if (start) begin
          mode_d = MODE;
          len_d = len_in;
          seed_d = SEED;
          idx_d = '0;
          busy_d = 1'b1;
          done_d = 1'b0;
          err_d = 1'b0;
          cnt_d = '0;
          state_d = len_in == '0 ? DONE : (MODE ? RD_ADDR : WR_ADDR);
        end
      end
      WR_ADDR: begin
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY) wvalid_d = 1'b0;
        if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) state_d = WR_RESP;
      end
      WR_RESP: if (M_AXI_BVALID) begin
        inc = {1'b0, M_AXI_BRESP != 2'b00};
        idx_d = last && !mode_q ? '0 : nxt;
        state_d = last ? (mode_q ? DONE : RD_ADDR) : (mode_q ? RD_ADDR : WR_ADDR);
      end
      RD_ADDR: if (M_AXI_ARREADY) state_d = RD_DATA;
      RD_DATA: if (M_AXI_RVALID) begin
        inc = 2'(M_AXI_RRESP != 2'b00) + 2'(!mode_q && miss);
        idx_d = mode_q ? idx_q : nxt;
        state_d = mode_q ? WR_ADDR : (last ? DONE : RD_ADDR);
      end
      default: state_d = IDLE;
    endcase
    // Address/data are loaded on entry so the channel registers stay stable while VALID is up
    if (state_d == WR_ADDR && state_q != WR_ADDR) begin
      awvalid_d = 1'b1;
      wvalid_d = 1'b1;
      awaddr_d = C_DST_BASE + off(idx_d);
      wdata_d = mode_d ? M_AXI_RDATA : seed_d + DW'(idx_d);
    end
    if (state_d == RD_ADDR && state_q != RD_ADDR) araddr_d = (mode_d ? C_SRC_BASE : C_DST_BASE) + off(idx_d);
    arvalid_d = state_d == RD_ADDR;
    bready_d = state_d == WR_RESP;
    rready_d = state_d == RD_DATA;
    sum = {1'b0, cnt_q} + 17'(inc);
    if (inc != 2'd0) begin
      cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
      err_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      init_q <= 1'b0;
      init_prev_q <= 1'b0;
      mode_q <= 1'b0;
      len_q <= '0;
      seed_q <= '0;
      idx_q <= '0;
      wdata_q <= '0;
      awaddr_q <= '0;
      araddr_q <= '0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      bready_q <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      init_q <= INIT_AXI_TXN;
      init_prev_q <= init_q;
      mode_q <= mode_d;
      len_q <= len_d;
      seed_q <= seed_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      awaddr_q <= awaddr_d;
      araddr_q <= araddr_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
      bready_q <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q <= rready_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign TXN_DONE = done_q;
  assign ERROR = err_q;
  assign BUSY = busy_q;
  assign ERR_COUNT = cnt_q;
  assign M_AXI_AWADDR = awaddr_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA = wdata_q;
  assign M_AXI_WSTRB = '1;
  assign M_AXI_WVALID = wvalid_q;
  assign M_AXI_BREADY = bready_q;
  assign M_AXI_ARADDR = araddr_q;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY = rready_q;
endmodule

// File: tb/tb_m_axi_lite_dma_v2.sv
// tb_m_axi_lite_dma_v2: directed bench with a memory-backed AXI4-Lite slave model.
module tb_m_axi_lite_dma_v2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic init = 1'b0, mode = 1'b0;
  logic [LW-1:0] len = '0;
  logic [DW-1:0] seed = '0;
  logic done, error, busy;
  logic [15:0] err_cnt;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0] bresp, rresp;

  m_axi_lite_dma_v2 dut (
    .ACLK(clk), .ARESETN(rst_n), .INIT_AXI_TXN(init), .MODE(mode), .XFER_LEN(len), .SEED(seed),
    .TXN_DONE(done), .ERROR(error), .BUSY(busy), .ERR_COUNT(err_cnt),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  logic [31:0] mem [0:2047];
  int wr_n = 0, rd_n = 0, outst = 0, viol = 0, vcyc = 0, o;
  int skew = 0, bad_w = -1, bad_r = -1, wr_base = 0, rd_base = 0;
  logic [31:0] corrupt = 32'h0;
  logic got_aw, got_w;
  logic [31:0] aw_a, w_d;
  bit log_q[$];
  int n_chk = 0, n_fail = 0;

  // Slave: word-addressed memory, optional random ready skew, response-error and data-corruption injection
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready <= 1'b0; wready <= 1'b0; arready <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
      bresp <= 2'b00; rresp <= 2'b00; rdata <= '0; got_aw <= 1'b0; got_w <= 1'b0; outst <= 0;
    end else begin
      o = outst;
      if (awvalid || wvalid || arvalid) vcyc <= vcyc + 1;
      awready <= skew != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      wready <= skew != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      arready <= 1'b1;
      if (awvalid && awready) begin got_aw <= 1'b1; aw_a <= awaddr; o++; log_q.push_back(1'b1); end
      if (wvalid && wready) begin got_w <= 1'b1; w_d <= wdata; end
      if (got_aw && got_w && !bvalid) begin
        mem[aw_a[12:2]] = w_d;
        bvalid <= 1'b1;
        bresp <= (wr_n - wr_base == bad_w) ? 2'b10 : 2'b00;
        got_aw <= 1'b0; got_w <= 1'b0;
      end
      if (bvalid && bready) begin bvalid <= 1'b0; wr_n <= wr_n + 1; o--; end
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata <= mem[araddr[12:2]] ^ (araddr == corrupt ? 32'h1 : 32'h0);
        rresp <= (rd_n - rd_base == bad_r) ? 2'b11 : 2'b00;
        o++; log_q.push_back(1'b0);
      end
      if (rvalid && rready) begin rvalid <= 1'b0; rd_n <= rd_n + 1; o--; end
      if (o > 1) viol <= viol + 1;
      outst <= o;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic m, input logic [LW-1:0] l, input logic [DW-1:0] s);
    @(posedge clk); #1;
    mode = m; len = l; seed = s; init = 1'b1;
    repeat (2) @(posedge clk);
    #1 init = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 3000 && !done; k++) begin @(posedge clk); #1; end
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic chk_order(input string tag, input int base);
    int bad = 0;
    for (int k = base; k < log_q.size(); k++) if (log_q[k] != 1'((k - base) % 2)) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    int w0, r0, v0, b;
    for (int k = 0; k < 2048; k++) mem[k] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wstrb", wstrb, 4'hF);
    chk("rst_prot", {awprot, arprot}, 0);
    rst_n = 1'b1;

    w0 = wr_n; r0 = rd_n;
    start(1'b0, 11'd4, 32'hA000_0000);
    wait_done("m0");
    chk("m0_error", error, 0);
    chk("m0_cnt", err_cnt, 0);
    chk("m0_busy", busy, 0);
    for (int k = 0; k < 4; k++) chk($sformatf("m0_mem%0d", k), mem[1024 + k], 32'hA000_0000 + 32'(k));
    chk("m0_writes", wr_n - w0, 4);
    chk("m0_reads", rd_n - r0, 4);

    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
    b = log_q.size();
    start(1'b1, 11'd3, 32'h0);
    wait_done("m1");
    chk("m1_dst0", mem[1024], 32'h11);
    chk("m1_dst1", mem[1025], 32'h22);
    chk("m1_dst2", mem[1026], 32'h33);
    chk_order("m1_order", b);
    chk("m1_len", log_q.size() - b, 6);
    chk("m1_cnt", err_cnt, 0);

    skew = 1; corrupt = 32'h4000_1014; v0 = viol;
    start(1'b0, 11'd8, 32'h1234_0000);
    wait_done("skew");
    chk("skew_error", error, 1);
    chk("skew_cnt", err_cnt, 1);
    chk("skew_outstanding", viol - v0, 0);
    chk("skew_mem5", mem[1029], 32'h1234_0005);
    chk("skew_mem7", mem[1031], 32'h1234_0007);
    skew = 0; corrupt = 32'h0;

    mem[0] = 32'hC0; mem[1] = 32'hC1; mem[2] = 32'hC2; mem[3] = 32'hC3;
    wr_base = wr_n; rd_base = rd_n; bad_w = 2; bad_r = 0;
    start(1'b1, 11'd4, 32'h0);
    wait_done("resp");
    chk("resp_cnt", err_cnt, 2);
    chk("resp_error", error, 1);
    chk("resp_dst0", mem[1024], 32'hC0);
    chk("resp_dst3", mem[1027], 32'hC3);
    bad_w = -1; bad_r = -1;

    v0 = vcyc;
    @(posedge clk); #1;
    mode = 1'b0; len = '0; init = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("len0_busy", busy, 1);
    chk("len0_done_early", done, 0);
    chk("len0_err_clr", {error, err_cnt}, 0);
    init = 1'b0;
    @(posedge clk); #1;
    chk("len0_done", done, 1);
    chk("len0_busy_off", busy, 0);
    chk("len0_valids", vcyc - v0, 0);

    w0 = wr_n; r0 = rd_n;
    start(1'b0, 11'd16, 32'h5555_0000);
    repeat (6) @(posedge clk);
    #1 mode = 1'b1; len = 11'd1; init = 1'b1;
    repeat (2) @(posedge clk);
    #1 init = 1'b0;
    wait_done("ign");
    chk("ign_writes", wr_n - w0, 16);
    chk("ign_reads", rd_n - r0, 16);
    chk("ign_cnt", err_cnt, 0);
    chk("ign_mem15", mem[1039], 32'h5555_000F);

    start(1'b0, 11'd16, 32'h7700_0000);
    for (int k = 0; k < 2000 && !(awvalid && awaddr == 32'h4000_101C); k++) begin @(posedge clk); #1; end
    chk("rst7_reach", awvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst7_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("rst7_status", {busy, done, error}, 0);
    chk("rst7_awaddr", awaddr, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    start(1'b0, 11'd2, 32'h9900_0000);
    wait_done("rst7_fresh");
    chk("rst7_mem0", mem[1024], 32'h9900_0000);
    chk("rst7_mem1", mem[1025], 32'h9900_0001);
    chk("rst7_cnt", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/m_axi_lite_dma_v2.md
Name: m_axi_lite_dma_v2

Overview:
- Parametrised AXI4-Lite master DMA engine; successor to the fixed single-pattern M00_AXI example master.
- Started by an init pulse; runs one of two modes:
  - MODE 0, pattern write then readback-compare.
  - MODE 1, word-by-word memory copy from a source region to a destination region.
- Sits between local control logic and an AXI4-Lite slave (BRAM controller or VIP slave).
- Reports done, sticky error and a mismatch/response-error count.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address width of the AXI port.
- C_M_AXI_DATA_WIDTH, 32, data width; legal values 32 or 64.
- C_SRC_BASE, 32'h4000_0000, byte base address of the MODE 1 source region.
- C_DST_BASE, 32'h4000_1000, byte base address of the destination region (both modes).
- C_MAX_WORDS, 1024, maximum transfer length in words; LW = clog2(C_MAX_WORDS)+1.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- INIT_AXI_TXN  in  1  start request; rising edge sampled.
- MODE  in  1  0 = pattern/compare, 1 = copy; sampled at start.
- XFER_LEN  in  LW  words to process; sampled at start; values above C_MAX_WORDS are clamped.
- SEED  in  C_M_AXI_DATA_WIDTH  pattern base for MODE 0; sampled at start.
- TXN_DONE  out  1  high from completion until the next accepted start.
- ERROR  out  1  sticky error; cleared on the next accepted start.
- BUSY  out  1  high while a run is in progress.
- ERR_COUNT  out  16  number of errors in the current run; saturates at 16'hFFFF.
- Write channels: M_AXI_AWADDR, AWPROT(3), AWVALID, AWREADY, WDATA, WSTRB, WVALID, WREADY, BRESP(2), BVALID, BREADY.
- Read channels: M_AXI_ARADDR, ARPROT(3), ARVALID, ARREADY, RDATA, RRESP(2), RVALID, RREADY.

Behaviour:
- Reset values (async assert, sync release):
  - All outputs 0.
  - FSM in IDLE.
  - All address/data registers 0.
  - AWPROT/ARPROT are constant 0; WSTRB is constant all-ones.
- Start:
  - INIT_AXI_TXN is registered once.
  - A rising edge in IDLE or DONE is accepted. On acceptance: latch MODE, XFER_LEN and SEED; clear TXN_DONE, ERROR, ERR_COUNT and the word index i; set BUSY the next cycle.
  - Edges while BUSY are ignored.
- XFER_LEN = 0: go IDLE -> DONE with no AXI traffic; TXN_DONE rises 2 cycles after the registered edge.
- Addressing:
  - Word i is at base + i*(C_M_AXI_DATA_WIDTH/8).
  - Arithmetic is modulo 2^C_M_AXI_ADDR_WIDTH; wrap is silent.
- FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE. Exactly one outstanding transaction at any time.
- Write transaction:
  - AWVALID and WVALID assert together in WR_ADDR.
  - Each deasserts independently on its own handshake (VALID & READY); neither waits for the other.
  - When both are done, go to WR_RESP with BREADY=1.
  - The B handshake ends the transaction.
- Read transaction:
  - ARVALID is held until ARREADY.
  - Then RD_DATA with RREADY=1; the R handshake ends the transaction and captures RDATA.
- MODE 0 sequence:
  - Write phase for i = 0..LEN-1, WDATA = SEED + i (truncated to data width).
  - Then i resets to 0 and a read phase reads DST words and compares each against SEED + i.
- MODE 1 sequence:
  - Per word: read SRC+i, then write DST+i with the captured RDATA. Repeat for i = 0..LEN-1.
- Error events, counted once each:
  - Each BRESP != 0 and each RRESP != 0.
  - Each MODE 0 compare mismatch; a response error on the same beat as a mismatch counts as 2.
  - Any error sets ERROR sticky.
  - In MODE 1, a read with RRESP != 0 still writes the returned data.
- Completion: after the last transaction, go to DONE: BUSY=0, TXN_DONE=1. Both are held until the next accepted start.
- Reset mid-run: all VALID/READY outputs drop immediately and the FSM returns to IDLE. The slave shares ARESETN, so no AXI recovery is needed.
- Timeouts: none; a hung slave stalls the engine indefinitely.

Test Plan:
- MODE 0, LEN=4, SEED=32'hA000_0000, zero-wait slave -> writes A0000000..A0000003 to 4000_1000..4000_100C, reads them back; TXN_DONE=1, ERROR=0, ERR_COUNT=0.
- MODE 1, LEN=3, SRC preloaded {11,22,33} -> DST words = {11,22,33}; each read precedes its write; ERR_COUNT=0.
- MODE 0, LEN=8, slave corrupts word 5 on readback and applies random AWREADY/WREADY skew (AW before W, W before AW) -> single outstanding transaction, ERROR=1, ERR_COUNT=1.
- Slave returns BRESP=2'b10 on write 2 and RRESP=2'b11 on read 0 in MODE 1 LEN=4 -> ERR_COUNT=2, run completes, ERROR=1.
- XFER_LEN=0 -> no VALID ever asserted, TXN_DONE 2 cycles after edge; second INIT edge while BUSY (LEN=16) ignored.
- ARESETN low at word 7 of a LEN=16 run -> all VALIDs 0 same cycle, outputs 0; a fresh start after release completes correctly.
